// File: rtl/seq_int_div.sv
// Multi-cycle restoring divider for sign-magnitude operands, one quotient bit per clock, MSB first.
// Optional remainder output is enabled by defining SEQ_DIV_REMAINDER_EN.
module seq_int_div #(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned DEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_BITS-1:0] numerator,
  input  logic [DEN_BITS-1:0] denominator,
  input  logic                sign_n,
  input  logic                sign_d,
  output logic                ready,
  output logic                done,
  output logic [NUM_BITS-1:0] quotient,
  output logic [DEN_BITS-1:0] remainder,
  output logic                sign,
  output logic                div_zero
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q;
  logic [NUM_BITS-1:0] num_q;
  logic [DEN_BITS-1:0] den_q;
  logic [DEN_BITS-1:0] prem_q;
  logic [NUM_BITS-1:0] quot_acc_q;
  logic [CntW-1:0]     k_q;
  logic                sign_n_q, sign_d_q;
  logic                ready_q, done_q, sign_q, div_zero_q;
  logic [NUM_BITS-1:0] quotient_q;

  logic [DEN_BITS:0]   shifted;
  logic                fits;
  logic [DEN_BITS-1:0] prem_d;
  logic [NUM_BITS-1:0] quot_fin;
  logic                sign_fin;

  // The partial remainder always stays below den, so the low DEN_BITS of the
  // modular subtraction are exact whenever the trial fits.
  always_comb begin
    shifted  = {prem_q, num_q[k_q]};
    fits     = shifted >= {1'b0, den_q};
    prem_d   = fits ? (shifted[DEN_BITS-1:0] - den_q) : shifted[DEN_BITS-1:0];
    quot_fin = (den_q == '0) ? '1 : quot_acc_q;
    sign_fin = (sign_n_q ^ sign_d_q) & (|quot_fin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_q      <= '0;
      den_q      <= '0;
      prem_q     <= '0;
      quot_acc_q <= '0;
      k_q        <= '0;
      sign_n_q   <= 1'b0;
      sign_d_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      quotient_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          // ready stays low through the done cycle so no start overlaps the result pulse
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (start) begin
            num_q      <= numerator;
            den_q      <= denominator;
            sign_n_q   <= sign_n;
            sign_d_q   <= sign_d;
            prem_q     <= '0;
            quot_acc_q <= '0;
            k_q        <= CntW'(NUM_BITS - 1);
            ready_q    <= 1'b0;
            state_q    <= (denominator == '0) ? StFin : StCalc;
          end
        end
        StCalc: begin
          prem_q     <= prem_d;
          quot_acc_q <= {quot_acc_q[NUM_BITS-2:0], fits};
          if (k_q == '0) begin
            state_q <= StFin;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        StFin: begin
          done_q     <= 1'b1;
          quotient_q <= quot_fin;
          sign_q     <= sign_fin;
          div_zero_q <= (den_q == '0);
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEQ_DIV_REMAINDER_EN
  logic [DEN_BITS-1:0] remainder_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder_q <= '0;
    end else if (state_q == StFin) begin
      remainder_q <= (den_q == '0) ? DEN_BITS'(num_q) : prem_q;
    end
  end

  assign remainder = remainder_q;
`else
  assign remainder = '0;
`endif

  assign ready    = ready_q;
  assign done     = done_q;
  assign quotient = quotient_q;
  assign sign     = sign_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_int_div.sv
// Scoreboard bench for seq_int_div: driver pushes model results, a negedge monitor pops on done.
// Expected remainder follows SEQ_DIV_REMAINDER_EN.
module tb_seq_int_div;

  localparam int NB = 8;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] numerator = '0;
  logic [DB-1:0] denominator = '0;
  logic          sign_n = 1'b0;
  logic          sign_d = 1'b0;
  logic          ready, done, sign, div_zero;
  logic [NB-1:0] quotient;
  logic [DB-1:0] remainder;

  seq_int_div #(.NUM_BITS(NB), .DEN_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .numerator  (numerator),
    .denominator(denominator),
    .sign_n     (sign_n),
    .sign_d     (sign_d),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .sign       (sign),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] q;
    logic [DB-1:0] r;
    logic          s;
    logic          dz;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   ready_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Reference: plain integer division on magnitudes, quotient sign forced positive on zero.
  function automatic exp_t model(input int n, input int d, input bit sn, input bit sd,
                                 input int c);
    exp_t m;
    int   rr;
    m.dz  = (d == 0);
    m.q   = m.dz ? NB'((1 << NB) - 1) : NB'(n / d);
    rr    = m.dz ? (n % (1 << DB)) : (n % d);
`ifdef SEQ_DIV_REMAINDER_EN
    m.r   = DB'(rr);
`else
    m.r   = (rr != 0) ? '0 : '0;
`endif
    m.s   = (sn ^ sd) && (m.q != 0);
    m.cyc = c + (m.dz ? 1 : NB + 1) + 1;
    return m;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready_next) begin
      chk("ready_after_done", 32'(ready), 1);
      ready_next <= 1'b0;
    end
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("sign", 32'(sign), 32'(e.s));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
      chk("ready_low_with_done", 32'(ready), 0);
      ready_next <= 1'b1;
    end
  end

  task automatic do_div(input int n, input int d, input bit sn, input bit sd, input bit push);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    start       = 1'b1;
    numerator   = NB'(n);
    denominator = DB'(d);
    sign_n      = sn;
    sign_d      = sd;
    if (push) sbq.push_back(model(n, d, sn, sd, cyc));
    @(negedge clk);
    start       = 1'b0;
    numerator   = NB'($urandom);
    denominator = DB'($urandom);
    sign_n      = 1'($urandom);
    sign_d      = 1'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sbq.size() != 0 || !ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_quotient"}, 32'(quotient), 0);
    chk({tag, "_remainder"}, 32'(remainder), 0);
    chk({tag, "_sign"}, 32'(sign), 0);
    chk({tag, "_div_zero"}, 32'(div_zero), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from the operating notes.
    do_div(200, 7, 0, 0, 1);
    do_div(100, 7, 1, 0, 1);
    do_div(3, 9, 1, 0, 1);
    do_div(255, 1, 0, 0, 1);
    do_div(255, 255, 0, 0, 1);
    do_div(0, 5, 0, 0, 1);
    do_div(37, 0, 0, 0, 1);
    do_div(10, 3, 0, 0, 1);
    do_div(5, 0, 1, 0, 1);
    do_div(0, 0, 1, 1, 1);

    // Starts while busy must be ignored.
    do_div(200, 7, 0, 0, 1);
    @(negedge clk);
    start = 1'b1; numerator = 8'd99; denominator = 8'd3; sign_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; numerator = 8'd50; denominator = 8'd0; sign_d = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_div(10, 3, 0, 1, 1);

    // Leave non-zero results visible, then abort mid-calculation.
    do_div(37, 0, 1, 0, 1);
    wait_idle();
    do_div(200, 7, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_done_low", 32'(done), 0);

    for (int i = 0; i < 150; i++) begin
      int n, d;
      n = int'($urandom_range(0, (1 << NB) - 1));
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, (1 << DB) - 1));
      do_div(n, d, 1'($urandom), 1'($urandom), 1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
